// File: rtl/ntt_result_collector.sv
// ntt_result_collector
//   Takes the valid-qualified output coefficient stream of the NTT1024 core.
//   Each word gets a final conditional subtraction (x >= q -> x - q). The
//   stream is then de-interleaved from 2^LANE_DEPTH lanes into natural order,
//   stored in a 2^MAX_DEPTH x DW buffer and read back by address.
//
// Parameters:
//   DW          coefficient word width
//   MAX_DEPTH   log2 of the largest supported ring size (buffer depth)
//   LANE_DEPTH  log2 of the interleave lane count (1 = even/odd)
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start             one-cycle pulse; arms a capture (samples ring_depth, q)
//   ring_depth, q     log2 ring size and modulus for the next capture
//   in_valid, in_data coefficient stream from the core (dout0)
//   rd_en, rd_addr    natural-order readback request
//   rd_data           buffered coefficient, 1-cycle latency, held when idle
//   busy / ready      capture in progress / buffer holds a complete result
//   cfg_err           sticky: start seen with an illegal ring_depth
//   ovf_err           sticky: in_valid seen outside a capture
//   sig               (only with CHECKSUM_EN) mod-2^DW sum of captured words
//
// Optional feature: define CHECKSUM_EN to add the sig output and its adder.
module ntt_result_collector #(
  parameter int DW         = 32,
  parameter int MAX_DEPTH  = 10,
  parameter int LANE_DEPTH = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           ring_depth,
  input  logic [DW-1:0]        q,
  input  logic                 in_valid,
  input  logic [DW-1:0]        in_data,
  input  logic                 rd_en,
  input  logic [MAX_DEPTH-1:0] rd_addr,
  output logic [DW-1:0]        rd_data,
  output logic                 busy,
  output logic                 ready,
  output logic                 cfg_err,
  output logic                 ovf_err
`ifdef CHECKSUM_EN
  ,
  output logic [DW-1:0]        sig
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    READY   = 2'd2
  } state_t;

  // Final reduction of a core output that may sit in [q, 2q).
  function automatic logic [DW-1:0] cond_sub(input logic [DW-1:0] x,
                                             input logic [DW-1:0] m);
    return (x >= m) ? (x - m) : x;
  endfunction

  state_t                 state;
  logic [3:0]             depth_reg;
  logic [DW-1:0]          q_reg;
  logic [MAX_DEPTH-1:0]   m;
  logic [DW-1:0]          mem [2**MAX_DEPTH];

  logic                   start_legal;
  logic                   accept_start;
  logic                   wr_en;
  logic                   last_word;
  logic [3:0]             lane_shift;
  logic [MAX_DEPTH-1:0]   last_idx;
  logic [MAX_DEPTH-1:0]   wr_addr;
  logic [DW-1:0]          wr_data;

  assign start_legal  = (ring_depth >= 4'(LANE_DEPTH + 1)) &&
                        (ring_depth <= 4'(MAX_DEPTH));
  assign accept_start = start && start_legal && (state != CAPTURE);
  assign wr_en        = (state == CAPTURE) && in_valid;

  // N-1 as a mask; a shift by MAX_DEPTH yields all ones, covering the full-size ring.
  assign last_idx     = ~({MAX_DEPTH{1'b1}} << depth_reg);
  assign last_word    = (m == last_idx);

  // Lane l occupies the block starting at l * (N/L); the position inside the
  // block is m >> LANE_DEPTH. N/L is a power of two, so shifts suffice.
  assign lane_shift   = depth_reg - 4'(LANE_DEPTH);
  assign wr_addr      = (m >> LANE_DEPTH) +
                        (MAX_DEPTH'(m[LANE_DEPTH-1:0]) << lane_shift);
  assign wr_data      = cond_sub(in_data, q_reg);

  // Control: FSM, word counter, status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      m       <= '0;
      busy    <= 1'b0;
      ready   <= 1'b0;
      cfg_err <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      if (start && !start_legal) cfg_err <= 1'b1;
      // Covers a start and an in_valid arriving together in IDLE: that word is dropped.
      if (in_valid && (state != CAPTURE)) ovf_err <= 1'b1;

      unique case (state)
        IDLE, READY: begin
          if (accept_start) begin
            state <= CAPTURE;
            m     <= '0;
            busy  <= 1'b1;
            ready <= 1'b0;
          end
        end
        CAPTURE: begin
          if (in_valid) begin
            if (last_word) begin
              state <= READY;
              m     <= '0;
              busy  <= 1'b0;
              ready <= 1'b1;
            end else begin
              m <= m + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Capture configuration; only meaningful once a capture has been accepted
  always_ff @(posedge clk) begin
    if (accept_start) begin
      depth_reg <= ring_depth;
      q_reg     <= q;
    end
  end

  // Buffer write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Buffer read port, one register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

`ifdef CHECKSUM_EN
  // Running checksum of the reduced words
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig <= '0;
    end else if (accept_start) begin
      sig <= '0;
    end else if (wr_en) begin
      sig <= sig + wr_data;
    end
  end
`endif

endmodule

// File: doc/ntt_result_collector.md
Name: ntt_result_collector

Overview:
- Parametrised output collector for the NTT1024 core; replaces the bench-side capture loop with synthesizable RTL.
- Captures the core's valid-qualified output coefficient stream and applies the final conditional subtraction (x >= q -> x - q).
- De-interleaves the stream from 2^LANE_DEPTH lanes into natural order for any ring size up to 2^MAX_DEPTH, and buffers it for random-access readout.
- Sits between NTT1024 dout0 and the host/readback path.

Parameters:
DW, 32, coefficient word width (in_data, q, rd_data)
MAX_DEPTH, 10, log2 of largest ring size; buffer holds 2^MAX_DEPTH words
LANE_DEPTH, 1, log2 of interleave lane count (1 = even/odd interleave)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; arms a capture
ring_depth  in  4  log2 ring size N; sampled on start
q  in  DW  modulus; sampled on start
in_valid  in  1  in_data qualifier
in_data  in  DW  coefficient from core (dout0)
rd_en  in  1  read strobe
rd_addr  in  MAX_DEPTH  natural-order index
rd_data  out  DW  buffered coefficient, 1-cycle latency
busy  out  1  high in CAPTURE
ready  out  1  high in READY
cfg_err  out  1  sticky: start with illegal ring_depth
ovf_err  out  1  sticky: in_valid outside CAPTURE

Behaviour:
- Reset: all outputs 0, FSM IDLE, counter m = 0. Buffer contents undefined, not cleared. Reset mid-capture aborts immediately; no partial READY.
- Definitions: N = 1 << ring_depth_reg; L = 1 << LANE_DEPTH.
- Legal ring_depth: LANE_DEPTH+1 .. MAX_DEPTH.
- start with illegal ring_depth: ignored, FSM unchanged, cfg_err set.
- FSM IDLE: legal start -> CAPTURE. On that edge: latch ring_depth and q, m <- 0, busy <- 1, ready <- 0.
- FSM CAPTURE, each in_valid cycle:
  - write r = (in_data >= q) ? in_data - q : in_data; unsigned DW-bit compare.
  - write address = (m >> LANE_DEPTH) + (m mod L) * (N / L); shifts only, no multiplier.
  - m <- m + 1.
  - On the write with m = N-1: next cycle busy = 0, ready = 1, FSM READY.
- CAPTURE, in_valid low: no write, m holds; gaps of any length allowed.
- FSM READY: rd_en registers mem[rd_addr] onto rd_data next cycle. rd_data holds its value when rd_en is low.
  - rd_addr >= N: returns stale buffer content, no error.
  - start from READY: re-arms (READY -> CAPTURE), ready drops the next cycle.
- start while in CAPTURE: ignored; the current capture continues.
- in_valid in IDLE or READY: ovf_err set, data discarded, buffer untouched.
- Sticky errors clear only on reset.
- Simultaneous start and in_valid in IDLE: start takes effect, that in_valid word is discarded, and ovf_err is set.
- rd_en during CAPTURE: allowed; returns current buffer content with 1-cycle latency (no read/write hazard guarantee).
- Buffer: single-port-write / single-port-read RAM, 2^MAX_DEPTH x DW, inferable as BRAM.

Optional Feature:
CHECKSUM_EN
- Defined: adds output sig [DW-1:0]. sig is cleared on accepted start and accumulates sig + r (mod 2^DW) per captured word. Value is valid when ready = 1 and is held in READY.
- Undefined: sig port and adder absent; no other change.

Test Plan:
1. Setup: ring_depth = 8, q = 3329, LANE_DEPTH = 1; stream m = 0..255 with in_data = m. Required: ready asserts the cycle after the 256th word; rd_addr 0 -> 0, 1 -> 2, 128 -> 1, 255 -> 255.
2. Same setup with in_data = 3329 + m for even m and m for odd m. Required: every readback value < 3329; rd_addr 5 -> 10.
3. Stream with in_valid toggling 1/0 every cycle. Required: result identical to case 1; ready asserts only after 256 valid words.
4. start with ring_depth = 1 or 11. Required: cfg_err = 1, busy stays 0. Then start with ring_depth = 6: 64-word capture works and cfg_err stays 1.
5. Reset pulse after 100 words. Required: busy = 0 and ready = 0 asynchronously. A new start plus 256 words gives correct results. in_valid pulsed in IDLE sets ovf_err.
6. With CHECKSUM_EN defined, run case 1. Required: sig = 32640 (0x7F80) at ready.
